// File: rtl/sequential_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// Define SEQDIV_EARLY_EXIT_EN to finish at once when dividend < divisor.
module sequential_divider #(
    parameter int WIDTH   = 16,
    parameter int WIDTH_C = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH_C-1:0] LAST_STEP = WIDTH_C'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   p_q, p_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [WIDTH-1:0]   d_q, d_d;
    logic [WIDTH_C-1:0] count_q, count_d;
    logic               dbz_q, dbz_d;

    // Shifted partial remainder needs WIDTH+1 bits; once reduced it is
    // always below the divisor, so the stored copy fits in WIDTH bits.
    logic [WIDTH:0]     p_shift;
    logic [WIDTH-1:0]   p_sub;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            p_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            count_q <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            q_q     <= q_d;
            d_q     <= d_d;
            count_q <= count_d;
            dbz_q   <= dbz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        q_d     = q_q;
        d_d     = d_q;
        count_d = count_q;
        dbz_d   = dbz_q;
        p_shift = {p_q, q_q[WIDTH-1]};
        // Only used when p_shift >= divisor, so the top bit cancels out.
        p_sub   = p_shift[WIDTH-1:0] - d_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    d_d     = divisor;
                    count_d = '0;
                    if (divisor == '0) begin
                        state_d = DONE;
                        p_d     = dividend;
                        q_d     = '1;
                        dbz_d   = 1'b1;
                    end
`ifdef SEQDIV_EARLY_EXIT_EN
                    else if (dividend < divisor) begin
                        state_d = DONE;
                        p_d     = dividend;
                        q_d     = '0;
                        dbz_d   = 1'b0;
                    end
`endif
                    else begin
                        state_d = CALC;
                        p_d     = '0;
                        q_d     = dividend;
                        dbz_d   = 1'b0;
                    end
                end
            end
            CALC: begin
                if (p_shift >= {1'b0, d_q}) begin
                    p_d = p_sub;
                    q_d = {q_q[WIDTH-2:0], 1'b1};
                end else begin
                    p_d = p_shift[WIDTH-1:0];
                    q_d = {q_q[WIDTH-2:0], 1'b0};
                end
                count_d = count_q + WIDTH_C'(1);
                if (count_q == LAST_STEP) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ready       = (state_q == IDLE);
    assign valid       = (state_q == DONE);
    assign quotient    = q_q;
    assign remainder   = p_q;
    assign div_by_zero = dbz_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_sequential_divider.sv
// Bench for sequential_divider: directed cases plus random traffic checked
// every cycle against a transaction-level model built on / and %.
module tb_sequential_divider;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  dividend = '0;
    logic [W-1:0]  divisor = '0;
    logic          ready;
    logic          valid;
    logic [W-1:0]  quotient;
    logic [W-1:0]  remainder;
    logic          div_by_zero;
    logic [1:0]    dbg_state;

    sequential_divider #(.WIDTH(W), .WIDTH_C(5)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .ready       (ready),
        .valid       (valid),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .dbg_state   (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // model: one transaction at a time, results from plain / and %
    int           edge_n     = 0;
    int           ready_from = -1;
    int           valid_edge = -1;
    logic [W-1:0] pend_q = '0, pend_r = '0, held_q = '0, held_r = '0;
    logic         pend_z = 1'b0, held_z = 1'b0;

    always @(posedge clk or negedge reset) begin : model
        int           e;
        int           lat;
        logic [W-1:0] nq, nr;
        logic         nz;
        if (!reset) begin
            held_q     <= '0;
            held_r     <= '0;
            held_z     <= 1'b0;
            valid_edge <= -1;
            ready_from <= edge_n - 1;
        end else begin
            e = edge_n + 1;
            edge_n <= e;
            if (start && (edge_n >= ready_from)) begin
                if (divisor == '0) begin
                    nq = '1; nr = dividend; nz = 1'b1; lat = 1;
                end else begin
                    nq = dividend / divisor; nr = dividend % divisor; nz = 1'b0; lat = W + 1;
`ifdef SEQDIV_EARLY_EXIT_EN
                    if (dividend < divisor) lat = 1;
`endif
                end
                pend_q     <= nq;
                pend_r     <= nr;
                pend_z     <= nz;
                valid_edge <= e + lat - 1;
                ready_from <= e + lat;
                if (lat == 1) begin
                    held_q <= nq; held_r <= nr; held_z <= nz;
                end
            end else if (e == valid_edge) begin
                held_q <= pend_q; held_r <= pend_r; held_z <= pend_z;
            end
        end
    end

    // scoreboard compare on the falling edge
    always @(negedge clk) begin : compare
        logic rexp, vexp;
        if (!reset) begin
            chk("rst_ready", {31'b0, ready}, 1);
            chk("rst_valid", {31'b0, valid}, 0);
            chk("rst_quotient", {16'b0, quotient}, 0);
            chk("rst_remainder", {16'b0, remainder}, 0);
            chk("rst_dbz", {31'b0, div_by_zero}, 0);
        end else begin
            rexp = (edge_n >= ready_from);
            vexp = (edge_n == valid_edge);
            chk("cyc_ready", {31'b0, ready}, {31'b0, rexp});
            chk("cyc_valid", {31'b0, valid}, {31'b0, vexp});
            if (rexp || vexp) begin
                chk("cyc_quotient", {16'b0, quotient}, {16'b0, held_q});
                chk("cyc_remainder", {16'b0, remainder}, {16'b0, held_r});
                chk("cyc_dbz", {31'b0, div_by_zero}, {31'b0, held_z});
            end
        end
    end

    // driver tasks (called #1 after a rising edge)
    int acc_edge = 0;

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        int g = 0;
        while (ready !== 1'b1 && g < 40) begin
            @(posedge clk); #1; g++;
        end
        n_checks++;
        if (g >= 40) begin
            n_fail++;
            $display("FAIL issue_ready_timeout actual=busy required=ready t=%0t", $time);
        end
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk); #1;
        acc_edge = edge_n;
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
    endtask

    task automatic wait_valid(input string tag, input logic [W-1:0] eq, input logic [W-1:0] er,
                              input logic ez, input int elat);
        while (valid !== 1'b1 && (edge_n - acc_edge) < 40) begin
            @(posedge clk); #1;
        end
        chk({tag, "_latency"}, edge_n - acc_edge + 1, elat);
        chk({tag, "_quotient"}, {16'b0, quotient}, {16'b0, eq});
        chk({tag, "_remainder"}, {16'b0, remainder}, {16'b0, er});
        chk({tag, "_dbz"}, {31'b0, div_by_zero}, {31'b0, ez});
        chk({tag, "_model_q"}, {16'b0, held_q}, {16'b0, eq});
        chk({tag, "_model_r"}, {16'b0, held_r}, {16'b0, er});
    endtask

    function automatic logic [W-1:0] rnd_operand();
        case ($urandom_range(0, 4))
            0:       return W'($urandom);
            1:       return W'($urandom_range(0, 15));
            2:       return '0;
            3:       return '1;
            default: return W'($urandom_range(0, 255));
        endcase
    endfunction

    int lat_small;
    int first_acc;

    initial begin
`ifdef SEQDIV_EARLY_EXIT_EN
        lat_small = 1;
`else
        lat_small = W + 1;
`endif
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        chk("post_reset_ready", {31'b0, ready}, 1);
        chk("post_reset_quotient", {16'b0, quotient}, 0);

        issue(16'd100, 16'd7);
        wait_valid("d100_7", 16'd14, 16'd2, 1'b0, 17);

        issue(16'hFFFF, 16'd1);
        first_acc = acc_edge;
        wait_valid("dffff_1", 16'hFFFF, 16'd0, 1'b0, 17);
        issue(16'hFFFF, 16'hFFFF);
        chk("b2b_spacing", acc_edge - first_acc, 18);
        wait_valid("dffff_ffff", 16'd1, 16'd0, 1'b0, 17);

        issue(16'd5, 16'd0);
        wait_valid("d5_0", 16'hFFFF, 16'd5, 1'b1, 1);
        issue(16'd9, 16'd3);
        wait_valid("d9_3", 16'd3, 16'd0, 1'b0, 17);

        issue(16'd3, 16'd10);
        wait_valid("d3_10", 16'd0, 16'd3, 1'b0, lat_small);

        issue(16'd1000, 16'd9);
        repeat (5) @(posedge clk);
        #1;
        chk("ready_in_calc", {31'b0, ready}, 0);
        start = 1'b1; dividend = 16'd50; divisor = 16'd5;
        @(posedge clk); #1;
        start = 1'b0;
        wait_valid("d1000_9_ignore", 16'd111, 16'd1, 1'b0, 17);

        issue(16'd1000, 16'd9);
        repeat (8) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("abort_ready", {31'b0, ready}, 1);
        chk("abort_valid", {31'b0, valid}, 0);
        chk("abort_quotient", {16'b0, quotient}, 0);
        chk("abort_remainder", {16'b0, remainder}, 0);
        chk("abort_dbz", {31'b0, div_by_zero}, 0);
        repeat (3) begin
            @(posedge clk); #1;
            chk("abort_no_valid", {31'b0, valid}, 0);
        end
        reset = 1'b1;
        chk("release_ready", {31'b0, ready}, 1);
        issue(16'd20, 16'd6);
        wait_valid("d20_6", 16'd3, 16'd2, 1'b0, 17);

        // random traffic, including start pulses while busy
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk); #1;
            start    = ($urandom_range(0, 2) == 0);
            dividend = rnd_operand();
            divisor  = rnd_operand();
        end
        @(posedge clk); #1;
        start = 1'b0;
        repeat (25) @(posedge clk);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sequential_divider.md
# sequential_divider

Multi-cycle unsigned restoring divider: the shift-subtract inverse of the team's shift-add sequential multiplier datapath. It accepts a dividend/divisor pair on a ready/start handshake and iterates one quotient bit per clock. It presents quotient and remainder with a one-cycle `valid` pulse. Divide-by-zero is flagged rather than trapped. It sits beside the multiplier in the arithmetic unit and shares its operand widths.

## Interface
- `WIDTH`, 16: dividend, divisor, quotient and remainder width.
- `WIDTH_C`, 5: iteration counter width; must satisfy 2^WIDTH_C > WIDTH.
- `clk`  input  1  sole clock, rising edge.
- `reset`  input  1  asynchronous, active-low reset (asserted when 0).
- `start`  input  1  request; sampled only while `ready`=1.
- `dividend`  input  WIDTH  numerator, sampled with accepted `start`.
- `divisor`  input  WIDTH  denominator, sampled with accepted `start`.
- `ready`  output  1  high only in IDLE.
- `valid`  output  1  one-cycle pulse; results are final.
- `quotient`  output  WIDTH  quotient; held until the next accepted `start`.
- `remainder`  output  WIDTH  remainder; held until the next accepted `start`.
- `div_by_zero`  output  1  qualifies the current result; held with it.

## Operation
- States are IDLE, CALC and DONE. The reset state is IDLE.
- Reset values:
  - `ready`=1, `valid`=0.
  - `quotient`=0, `remainder`=0, `div_by_zero`=0.
  - Internal registers and counter are 0.
- IDLE with `start`=1 accepts the operands.
  - If `divisor`==0: go to DONE. Set Q=all ones, R=`dividend`, `div_by_zero`=1.
  - Otherwise, load the partial remainder P (WIDTH+1 bits) with 0 and Q with `dividend`. Set count=0, clear `div_by_zero`, go to CALC.
- CALC performs one step per edge:
  - Shift {P,Q} left 1.
  - If the shifted P >= divisor, P = P - divisor and Q[0]=1; else Q[0]=0.
  - Increment count.
- After step WIDTH (count==WIDTH-1 at that edge), go to DONE.
- DONE drives `valid`=1 for exactly one cycle, then goes to IDLE unconditionally.
- `quotient`/`remainder` are driven from the Q and P[WIDTH-1:0] registers. They are stable from the `valid` cycle until the next accepted `start`.
- Arithmetic:
  - Unsigned only.
  - Comparison and subtract use WIDTH+1 bits, so no overflow.
  - The result always satisfies dividend = Q*divisor + R with R < divisor (divisor≠0).
- Boundary conditions:
  - `start` while in CALC or DONE: ignored; operands not sampled.
  - Operand changes after acceptance: no effect.
  - Dividend 0 with nonzero divisor: full iteration path, giving Q=0, R=0 (unless the macro below applies).
  - Reset mid-CALC: abort immediately to reset values. No `valid` is issued.

## Timing
- Start accepted at edge E0. In CALC, steps run on E1..EWIDTH, and `valid` is high in the cycle after EWIDTH. Latency is WIDTH+1 edges.
- `ready` returns high the cycle after `valid`. Back-to-back throughput is one result per WIDTH+2 cycles.
- Divide-by-zero: `valid` is high in the cycle after E0 (latency 1).
- All outputs are registered or decoded from state. No combinational path runs from inputs to outputs.

## Configuration
- `SEQDIV_EARLY_EXIT_EN` defined:
  - At acceptance, if `divisor`≠0 and `dividend` < `divisor`, go straight to DONE with Q=0, R=`dividend`.
  - `valid` then comes in the cycle after E0. This includes dividend==0.
- Undefined: such operands take the full WIDTH-step CALC path and produce identical results at latency WIDTH+1.

## Test plan
- 100/7, WIDTH=16 -> Q=14, R=2, `div_by_zero`=0; `valid` exactly 17 edges after the start edge; `ready`=0 throughout CALC.
- 0xFFFF/1 and 0xFFFF/0xFFFF -> Q=0xFFFF, R=0; then Q=1, R=0. Both at full latency, back to back, 18 cycles apart.
- 5/0 -> Q=0xFFFF, R=5, `div_by_zero`=1, `valid` one cycle after acceptance. A following 9/3 clears the flag: Q=3, R=0.
- 3/10 -> Q=0, R=3. With `SEQDIV_EARLY_EXIT_EN` the latency is 1 edge; without it, 17 edges.
- 1000/9 accepted, then `start` with 50/5 pulsed mid-CALC -> second request ignored; result Q=111, R=1; `ready` high only after `valid`.
- 1000/9 accepted, `reset` driven low at step 8 -> all outputs at reset values immediately, no `valid`; after release, `ready`=1 and a new 20/6 gives Q=3, R=2.
